// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  // Sequencer states: CLEAR zeroes the array after reset, READY is normal use.
  typedef enum logic {
    CLEAR,
    READY
  } rf_state_t;

  // Address width for a given depth, never narrower than one bit.
  function automatic int rf_aw(input int depth);
    int aw;
    aw = $clog2(depth);
    return (aw < 1) ? 1 : aw;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: walks every entry after reset and writes zero into it,
// holding the file busy until the last entry has been cleared.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  output logic          init_busy_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o
);

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;

  // State and pointer registers; reset restarts the sweep from entry 0.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Advance the sweep one entry per cycle and leave CLEAR after the last one.
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    clr_we_o    = 1'b0;
    init_busy_o = 1'b0;
    clr_addr_o  = clr_ptr_q;
    if (state_q == CLEAR) begin
      init_busy_o = 1'b1;
      clr_we_o    = rst_ni;
      clr_ptr_d   = clr_ptr_q + 1'b1;
      if (clr_ptr_q == LastAddr) begin
        state_d = READY;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with NREAD combinational read ports,
// write-to-read bypass, optional hardwired zero register and a
// post-reset clear sequencer.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int  WIDTH    = 32,
  parameter int  DEPTH    = 32,
  parameter int  NREAD    = 2,
  parameter int  ZERO_REG = 1,
  localparam int AW       = rf_aw(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   RegWrite,
  input  logic [AW-1:0]          w_reg,
  input  logic [WIDTH-1:0]       write_data,
  input  logic [NREAD*AW-1:0]    r_reg,
  output logic [NREAD*WIDTH-1:0] r_data,
  output logic                   init_busy
);

  localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             clrWe;
  logic [AW-1:0]    clrAddr;
  logic             userWe;
  logic             memWe;
  logic [AW-1:0]    memAddr;
  logic [WIDTH-1:0] memData;

  regfile_clear_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .init_busy_o (init_busy),
    .clr_we_o    (clrWe),
    .clr_addr_o  (clrAddr)
  );

  // A user write only lands when the file is ready, the address exists and
  // it does not target the hardwired zero register.
  assign userWe = !init_busy && RegWrite
                  && ({1'b0, w_reg} < DepthW)
                  && !((ZERO_REG != 0) && (w_reg == '0));

  // Array write port is owned by the sequencer while clearing, else by writeback.
  always_comb begin
    memWe   = 1'b0;
    memAddr = w_reg;
    memData = write_data;
    if (clrWe) begin
      memWe   = 1'b1;
      memAddr = clrAddr;
      memData = '0;
    end else if (userWe) begin
      memWe = 1'b1;
    end
  end

  // Storage has no reset of its own; the sequencer zeroes it.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem_q[memAddr] <= memData;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_read
    logic [AW-1:0]    rAddr;
    logic [WIDTH-1:0] rVal;

    assign rAddr = r_reg[i*AW +: AW];

    // Each port masks while busy, masks invalid/zero addresses, then
    // prefers the in-flight write over the stored value.
    always_comb begin
      rVal = '0;
      if (init_busy) begin
        rVal = '0;
      end else if (({1'b0, rAddr} >= DepthW) || ((ZERO_REG != 0) && (rAddr == '0))) begin
        rVal = '0;
      end else if (userWe && (w_reg == rAddr)) begin
        rVal = write_data;
      end else begin
        rVal = mem_q[rAddr];
      end
    end

    assign r_data[i*WIDTH +: WIDTH] = rVal;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a 3-port 32-entry file with zero register,
// a 1-port file without zero register and a 2-port 20-entry file.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        RegWriteA;
  logic [4:0]  wRegA;
  logic [31:0] wDataA;
  logic [14:0] rRegA;
  logic [95:0] rDataA;
  logic        busyA;

  logic        RegWriteB;
  logic [4:0]  wRegB;
  logic [31:0] wDataB;
  logic [4:0]  rRegB;
  logic [31:0] rDataB;
  logic        busyB;

  logic        RegWriteC;
  logic [4:0]  wRegC;
  logic [31:0] wDataC;
  logic [9:0]  rRegC;
  logic [63:0] rDataC;
  logic        busyC;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NREAD(3), .ZERO_REG(1)) dutA (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWriteA), .w_reg(wRegA),
    .write_data(wDataA), .r_reg(rRegA), .r_data(rDataA), .init_busy(busyA)
  );

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NREAD(1), .ZERO_REG(0)) dutB (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWriteB), .w_reg(wRegB),
    .write_data(wDataB), .r_reg(rRegB), .r_data(rDataB), .init_busy(busyB)
  );

  regfile_mp #(.WIDTH(32), .DEPTH(20), .NREAD(2), .ZERO_REG(1)) dutC (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWriteC), .w_reg(wRegC),
    .write_data(wDataC), .r_reg(rRegC), .r_data(rDataC), .init_busy(busyC)
  );

  // One comparison: counts it, and reports observed/expected on failure.
  task automatic checkOutput(input string tag, input logic [95:0] observed,
                             input logic [95:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Drives the 3-port file's inputs and lets the read muxes settle.
  task automatic applyStimulus(input logic we, input logic [4:0] wreg,
                               input logic [31:0] wdata, input logic [14:0] rreg);
    RegWriteA = we;
    wRegA     = wreg;
    wDataA    = wdata;
    rRegA     = rreg;
    #1;
  endtask

  // Advance past the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    int cntC;
    bit zeroBad;

    rst_n = 1'b0;
    RegWriteB = 1'b0; wRegB = '0; wDataB = '0; rRegB = '0;
    RegWriteC = 1'b0; wRegC = '0; wDataC = '0; rRegC = '0;
    applyStimulus(1'b0, 5'd0, 32'h0, {5'd7, 5'd6, 5'd5});

    // Reset held for three edges.
    repeat (3) tick();
    checkOutput("resetBusyA", 96'(busyA), 96'd1);
    checkOutput("resetBusyC", 96'(busyC), 96'd1);
    checkOutput("resetReadA", rDataA, 96'h0);

    // Release reset; a write held through the whole clear must be ignored.
    rst_n = 1'b1;
    applyStimulus(1'b1, 5'd3, 32'h1111_1111, {5'd3, 5'd3, 5'd1});
    cnt = 0;
    cntC = 0;
    zeroBad = 1'b0;
    while (busyA === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
      if (busyA === 1'b1 && rDataA !== 96'h0) zeroBad = 1'b1;
      if (busyC === 1'b0 && cntC == 0) cntC = cnt;
    end
    checkOutput("clearLenA", 96'(cnt), 96'd32);
    checkOutput("clearLenB", 96'(busyB), 96'd0);
    checkOutput("clearLenC", 96'(cntC), 96'd20);
    checkOutput("clearReadsZero", 96'(zeroBad), 96'd0);

    // Write held during the last clear cycle was dropped.
    applyStimulus(1'b0, 5'd3, 32'h0, {5'd3, 5'd3, 5'd3});
    checkOutput("lastClearWriteDropped", rDataA, 96'h0);
    for (int a = 0; a < 32; a++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, {5'd0, 5'd0, 5'(a)});
      checkOutput($sformatf("clearedAddr%0d", a), rDataA, 96'h0);
    end

    // Write r5 and r6, then read {5,6,5}.
    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 15'd0);
    tick();
    applyStimulus(1'b1, 5'd6, 32'h1234_5678, 15'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, {5'd5, 5'd6, 5'd5});
    checkOutput("readThreePorts", rDataA, {32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF});

    // Bypass on two ports while port 2 reads stored r5.
    applyStimulus(1'b0, 5'd7, 32'h0, {5'd5, 5'd7, 5'd7});
    checkOutput("r7OldValue", rDataA[31:0], 96'h0);
    applyStimulus(1'b1, 5'd7, 32'hA5A5_A5A5, {5'd5, 5'd7, 5'd7});
    checkOutput("bypass", rDataA, {32'hDEAD_BEEF, 32'hA5A5_A5A5, 32'hA5A5_A5A5});
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, {5'd0, 5'd0, 5'd7});
    checkOutput("r7Stored", rDataA, {64'h0, 32'hA5A5_A5A5});

    // Back-to-back writes to r9: latest value wins, also via bypass.
    applyStimulus(1'b1, 5'd9, 32'h0000_0001, 15'd0);
    tick();
    applyStimulus(1'b1, 5'd9, 32'h0000_0002, {5'd0, 5'd0, 5'd9});
    checkOutput("b2bBypass", rDataA, 96'h2);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, {5'd0, 5'd0, 5'd9});
    checkOutput("b2bStored", rDataA, 96'h2);

    // Zero register: writes to r0 never show up.
    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 15'd0);
    checkOutput("zeroRegSameCycle", rDataA, 96'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 15'd0);
    checkOutput("zeroRegAfter", rDataA, 96'h0);

    // Without a zero register r0 behaves like any other entry.
    RegWriteB = 1'b1; wRegB = 5'd0; wDataB = 32'hFFFF_FFFF; rRegB = 5'd0;
    #1;
    checkOutput("noZeroBypass", 96'(rDataB), 96'hFFFF_FFFF);
    tick();
    RegWriteB = 1'b0;
    #1;
    checkOutput("noZeroStored", 96'(rDataB), 96'hFFFF_FFFF);

    // Non-power-of-two depth: out-of-range write dropped and masked.
    RegWriteC = 1'b1; wRegC = 5'd19; wDataC = 32'h1313_1313; rRegC = '0;
    tick();
    RegWriteC = 1'b1; wRegC = 5'd25; wDataC = 32'h0BAD_0BAD; rRegC = {5'd19, 5'd25};
    #1;
    checkOutput("oorSameCycle", 96'(rDataC), {32'h0, 32'h1313_1313, 32'h0});
    tick();
    RegWriteC = 1'b0;
    #1;
    checkOutput("oorAfter", 96'(rDataC), {32'h0, 32'h1313_1313, 32'h0});

    // Store r31, then reset mid-clear and confirm a full restart.
    applyStimulus(1'b1, 5'd31, 32'hCAFE_F00D, 15'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, {5'd31, 5'd9, 5'd5});
    checkOutput("preResetContents", rDataA, {32'hCAFE_F00D, 32'h2, 32'hDEAD_BEEF});
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    checkOutput("midClearBusy", 96'(busyA), 96'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cnt = 0;
    while (busyA === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    checkOutput("restartClearLen", 96'(cnt), 96'd32);
    applyStimulus(1'b0, 5'd0, 32'h0, {5'd31, 5'd9, 5'd5});
    checkOutput("postRestartZero", rDataA, 96'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
